// File: rtl/missile_pkg.sv
// Shared types and default geometry for the missile controller and its respawn timers.
package missile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } state_e;

    typedef enum logic {
        OWN_DRAGON = 1'b0,
        OWN_ROBOT  = 1'b1
    } owner_e;

    localparam logic [9:0] PARK = 10'd1023;

    localparam int unsigned DEF_STEP           = 32'd4;
    localparam int unsigned DEF_SCREEN_W       = 32'd640;
    localparam int unsigned DEF_SPR_W          = 32'd40;
    localparam int unsigned DEF_M_W            = 32'd90;
    localparam int unsigned DEF_COOL_FRAMES    = 32'd15;
    localparam int unsigned DEF_RESPAWN_FRAMES = 32'd120;

    // Launch sums are formed at 11 bits; anything past the 10-bit range pins to the far edge.
    function automatic logic [9:0] sat10(input logic [10:0] v);
        return v[10] ? 10'h3FF : v[9:0];
    endfunction

endpackage

// File: rtl/respawn_timer.sv
// Per-sprite alive flag: a hit clears it, and it returns after a fixed number of frames.
module respawn_timer
    import missile_pkg::*;
#(
    parameter int unsigned RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
)
(
    input  logic clk_25Hz,
    input  logic rst,
    input  logic hit_edge,
    input  logic frame_tick,
    output logic valid
);

    localparam logic [7:0] RELOAD = 8'(RESPAWN_FRAMES);

    logic       valid_q;
    logic [7:0] cnt_q;

    // A new hit always reloads, even while already invalid.
    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b1;
            cnt_q   <= 8'd0;
        end else if (hit_edge) begin
            valid_q <= 1'b0;
            cnt_q   <= RELOAD;
        end else if (!valid_q && frame_tick) begin
            if (cnt_q <= 8'd1) begin
                cnt_q   <= 8'd0;
                valid_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_q - 8'd1;
            end
        end
    end

    assign valid = valid_q;

endmodule

// File: rtl/missile_ctrl.sv
// Shares one missile sprite between dragon and robot: arbitration, flight, retire,
// cooldown, and the sprites' alive flags.
module missile_ctrl
    import missile_pkg::*;
#(
    parameter int unsigned STEP           = DEF_STEP,
    parameter int unsigned SCREEN_W       = DEF_SCREEN_W,
    parameter int unsigned SPR_W          = DEF_SPR_W,
    parameter int unsigned M_W            = DEF_M_W,
    parameter int unsigned COOL_FRAMES    = DEF_COOL_FRAMES,
    parameter int unsigned RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter logic [9:0]  PARK_XY        = PARK
)
(
    input  logic       clk_25Hz,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       d_fire,
    input  logic       r_fire,
    input  logic [9:0] d_x,
    input  logic [9:0] d_y,
    input  logic [9:0] r_x,
    input  logic [9:0] r_y,
    input  logic [1:0] Event,
    output logic [9:0] m_x,
    output logic [9:0] m_y,
    output logic       m_active,
    output logic       m_owner,
    output logic       d_grant,
    output logic       r_grant,
    output logic       d_valid,
    output logic       r_valid
);

    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [9:0]  STEP10  = 10'(STEP);
    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [9:0]  M_W10   = 10'(M_W);
    localparam logic [10:0] EDGE11  = 11'(SCREEN_W - M_W);
    localparam logic [7:0]  COOL8   = 8'(COOL_FRAMES);

    state_e      state_q;
    owner_e      last_owner_q;
    owner_e      m_owner_q;
    logic [9:0]  m_x_q;
    logic [9:0]  m_y_q;
    logic        m_active_q;
    logic        d_grant_q;
    logic        r_grant_q;
    logic [7:0]  cool_q;
    logic [1:0]  ev_prev_q;

    logic [1:0]  ev_rise_s;
    logic        d_valid_s;
    logic        r_valid_s;
    logic        d_elig_s;
    logic        r_elig_s;
    logic        launch_s;
    owner_e      winner_s;
    logic [10:0] d_launch_s;
    logic [9:0]  r_launch_s;
    logic [10:0] m_fwd_s;
    logic        edge_hit_s;
    logic        retire_s;

    assign ev_rise_s = Event & ~ev_prev_q;

    // Arbitration: on a tie the requester that did not fire last wins; the loser is dropped.
    always_comb begin
        d_elig_s = d_fire & d_valid_s;
        r_elig_s = r_fire & r_valid_s;
        launch_s = d_elig_s | r_elig_s;
        if (d_elig_s && r_elig_s) begin
            winner_s = (last_owner_q == OWN_ROBOT) ? OWN_DRAGON : OWN_ROBOT;
        end else if (d_elig_s) begin
            winner_s = OWN_DRAGON;
        end else begin
            winner_s = OWN_ROBOT;
        end
    end

    // Geometry: launch points and whether the next step would leave the screen.
    always_comb begin
        d_launch_s = {1'b0, d_x} + SPR_W11;
        r_launch_s = (r_x < M_W10) ? 10'd0 : (r_x - M_W10);
        m_fwd_s    = {1'b0, m_x_q} + STEP11;
        if (m_owner_q == OWN_DRAGON) begin
            edge_hit_s = (m_fwd_s > EDGE11);
        end else begin
            edge_hit_s = (m_x_q < STEP10);
        end
        retire_s = (state_q == FLY) && ((|ev_rise_s) || (frame_tick && edge_hit_s));
    end

    // Missile FSM with registered outputs; a collision edge beats a same-cycle move.
    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_ROBOT;
            m_owner_q    <= OWN_DRAGON;
            m_x_q        <= PARK_XY;
            m_y_q        <= PARK_XY;
            m_active_q   <= 1'b0;
            d_grant_q    <= 1'b0;
            r_grant_q    <= 1'b0;
            cool_q       <= 8'd0;
            ev_prev_q    <= 2'b00;
        end else begin
            ev_prev_q <= Event;
            d_grant_q <= 1'b0;
            r_grant_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch_s) begin
                        state_q      <= FLY;
                        m_active_q   <= 1'b1;
                        m_owner_q    <= winner_s;
                        last_owner_q <= winner_s;
                        if (winner_s == OWN_DRAGON) begin
                            m_x_q     <= sat10(d_launch_s);
                            m_y_q     <= d_y;
                            d_grant_q <= 1'b1;
                        end else begin
                            m_x_q     <= r_launch_s;
                            m_y_q     <= r_y;
                            r_grant_q <= 1'b1;
                        end
                    end
                end
                FLY: begin
                    if (retire_s) begin
                        state_q    <= COOL;
                        m_x_q      <= PARK_XY;
                        m_y_q      <= PARK_XY;
                        m_active_q <= 1'b0;
                        cool_q     <= COOL8;
                    end else if (frame_tick) begin
                        if (m_owner_q == OWN_DRAGON) begin
                            m_x_q <= m_fwd_s[9:0];
                        end else begin
                            m_x_q <= m_x_q - STEP10;
                        end
                    end
                end
                COOL: begin
                    if (frame_tick) begin
                        if (cool_q <= 8'd1) begin
                            cool_q  <= 8'd0;
                            state_q <= IDLE;
                        end else begin
                            cool_q  <= cool_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    m_x_q      <= PARK_XY;
                    m_y_q      <= PARK_XY;
                    m_active_q <= 1'b0;
                    cool_q     <= 8'd0;
                end
            endcase
        end
    end

    respawn_timer #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_dragon_respawn (
        .clk_25Hz   (clk_25Hz),
        .rst        (rst),
        .hit_edge   (ev_rise_s[1]),
        .frame_tick (frame_tick),
        .valid      (d_valid_s)
    );

    respawn_timer #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_robot_respawn (
        .clk_25Hz   (clk_25Hz),
        .rst        (rst),
        .hit_edge   (ev_rise_s[0]),
        .frame_tick (frame_tick),
        .valid      (r_valid_s)
    );

    assign m_x      = m_x_q;
    assign m_y      = m_y_q;
    assign m_active = m_active_q;
    assign m_owner  = m_owner_q;
    assign d_grant  = d_grant_q;
    assign r_grant  = r_grant_q;
    assign d_valid  = d_valid_s;
    assign r_valid  = r_valid_s;

endmodule
